// File: rtl/ber_checker.sv
// BER checker: decimates the filtered oversampled stream, slices to one bit, searches the
// reference delay, locks and counts bits/errors. Define BER_RELOCK_EN to drop lock on bursts.
module ber_checker #(
  parameter int NB_INPUT   = 8,
  parameter int OS         = 4,
  parameter int DELAY_LEN  = 511,
  parameter int SEARCH_WIN = 32,
  parameter int NB_CNT     = 32,
  parameter int RELOCK_TH  = 4
) (
  input  logic                         clk,
  input  logic                         i_srst,
  input  logic                         i_en,
  input  logic [NB_INPUT-1:0]          i_is_data,
  input  logic                         i_ref_bit,
  input  logic [$clog2(OS)-1:0]        i_phase,
  output logic                         o_sym_valid,
  output logic                         o_sym_bit,
  output logic                         o_locked,
  output logic [$clog2(DELAY_LEN)-1:0] o_delay,
  output logic [NB_CNT-1:0]            o_bit_cnt,
  output logic [NB_CNT-1:0]            o_err_cnt
);

  localparam int PW = $clog2(OS);
  localparam int DW = $clog2(DELAY_LEN);
  localparam int WW = $clog2(SEARCH_WIN + 1);

  localparam logic [PW-1:0]     PH_LAST   = PW'(OS - 1);
  localparam logic [DW-1:0]     DLY_LAST  = DW'(DELAY_LEN - 1);
  localparam logic [WW-1:0]     WIN_LAST  = WW'(SEARCH_WIN - 1);
  localparam logic [NB_CNT-1:0] CNT_MAX   = '1;
  localparam bit                RELOCK_OK = (RELOCK_TH < SEARCH_WIN);
`ifdef BER_RELOCK_EN
  localparam logic [WW-1:0]     RELOCK_LIM = WW'(RELOCK_TH);
`endif

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [PW-1:0]        ph_cnt;
  logic [DELAY_LEN-1:0] ref_sr;
  logic [WW-1:0]        win_cnt;
  logic [WW-1:0]        win_err;
  logic [WW-1:0]        win_err_tot;
  logic                 strobe;
  logic                 slice_bit;
  logic                 ref_tap;
  logic                 err;
  logic                 win_run;
  logic                 win_clr;
  logic                 go_lock;
  logic                 step_delay;

  // o_sym_valid is a one-cycle pulse with no back-pressure; o_sym_bit is meaningful only while it is high.
  assign strobe      = i_en & (ph_cnt == i_phase);
  // Zero carries no sign information and is forced to slice as 0.
  assign slice_bit   = i_is_data[NB_INPUT-1] & (|i_is_data);
  assign ref_tap     = ref_sr[o_delay];
  assign err         = slice_bit ^ ref_tap;
  assign win_err_tot = win_err + WW'(err);
  assign o_locked    = (state_q == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (i_srst) begin
      ph_cnt <= '0;
    end else if (i_en) begin
      ph_cnt <= (ph_cnt == PH_LAST) ? '0 : ph_cnt + 1'b1;
    end
  end

  // Compare uses the pre-shift tap: sr[k] holds the reference from k+1 strobes back.
  always_ff @(posedge clk) begin
    if (i_srst) begin
      ref_sr <= '0;
    end else if (strobe) begin
      ref_sr <= {ref_sr[DELAY_LEN-2:0], i_ref_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (i_srst) begin
      o_sym_valid <= 1'b0;
      o_sym_bit   <= 1'b0;
    end else begin
      o_sym_valid <= strobe;
      if (strobe) begin
        o_sym_bit <= slice_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_srst) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    win_run    = 1'b0;
    win_clr    = 1'b0;
    go_lock    = 1'b0;
    step_delay = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        win_run = strobe;
        if (strobe && (win_cnt == WIN_LAST)) begin
          win_clr = 1'b1;
          if (win_err_tot == '0) begin
            state_d = ST_LOCKED;
            go_lock = 1'b1;
          end else begin
            step_delay = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
`ifdef BER_RELOCK_EN
        win_run = strobe;
        if (strobe && (win_cnt == WIN_LAST)) begin
          win_clr = 1'b1;
          if (win_err_tot > RELOCK_LIM) begin
            state_d    = ST_SEARCH;
            step_delay = 1'b1;
          end
        end
`endif
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_srst) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (win_clr) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (win_run) begin
      win_cnt <= win_cnt + 1'b1;
      win_err <= win_err_tot;
    end
  end

  always_ff @(posedge clk) begin
    if (i_srst) begin
      o_delay <= '0;
    end else if (step_delay) begin
      o_delay <= (o_delay == DLY_LAST) ? '0 : o_delay + 1'b1;
    end
  end

  // Both counters saturate independently; a relock drop leaves them holding.
  always_ff @(posedge clk) begin
    if (i_srst || go_lock) begin
      o_bit_cnt <= '0;
      o_err_cnt <= '0;
    end else if (strobe && (state_q == ST_LOCKED)) begin
      if (o_bit_cnt != CNT_MAX) begin
        o_bit_cnt <= o_bit_cnt + 1'b1;
      end
      if (err && (o_err_cnt != CNT_MAX)) begin
        o_err_cnt <= o_err_cnt + 1'b1;
      end
    end
  end

  a_relock_th_range: assert property (@(posedge clk) RELOCK_OK);

  a_valid_follows_en: assert property (@(posedge clk) disable iff (i_srst)
    o_sym_valid |-> $past(i_en));

  a_err_le_bits: assert property (@(posedge clk) o_err_cnt <= o_bit_cnt);

  a_hold_when_idle: assert property (@(posedge clk) (!i_en && !i_srst) |=>
    ($stable(o_bit_cnt) && $stable(o_err_cnt) && $stable(o_delay) && $stable(o_locked)));

endmodule

// File: tb/tb_ber_checker.sv
// Bench for ber_checker: PRBS9-driven random stimulus, queue-based reference model and
// scoreboard monitor on o_sym_valid, plus directed lock/error/freeze/wrap checks.
module tb_ber_checker;

  localparam int NB_INPUT   = 8;
  localparam int OS         = 4;
  localparam int DELAY_LEN  = 511;
  localparam int SEARCH_WIN = 32;
  localparam int NB_CNT     = 32;
  localparam int RELOCK_TH  = 4;
  localparam int DW         = 9;
  localparam int EW         = 2 + DW + 2 * NB_CNT;
  localparam int N_PRBS     = 16500;
  localparam longint CNT_MAX = (longint'(1) << NB_CNT) - 1;

  logic              tb_clk;
  logic              i_srst;
  logic              i_en;
  logic [NB_INPUT-1:0] i_is_data;
  logic              i_ref_bit;
  logic [1:0]        i_phase;
  logic              o_sym_valid;
  logic              o_sym_bit;
  logic              o_locked;
  logic [DW-1:0]     o_delay;
  logic [NB_CNT-1:0] o_bit_cnt;
  logic [NB_CNT-1:0] o_err_cnt;

  ber_checker #(
    .NB_INPUT  (NB_INPUT),
    .OS        (OS),
    .DELAY_LEN (DELAY_LEN),
    .SEARCH_WIN(SEARCH_WIN),
    .NB_CNT    (NB_CNT),
    .RELOCK_TH (RELOCK_TH)
  ) dut (
    .clk        (tb_clk),
    .i_srst     (i_srst),
    .i_en       (i_en),
    .i_is_data  (i_is_data),
    .i_ref_bit  (i_ref_bit),
    .i_phase    (i_phase),
    .o_sym_valid(o_sym_valid),
    .o_sym_bit  (o_sym_bit),
    .o_locked   (o_locked),
    .o_delay    (o_delay),
    .o_bit_cnt  (o_bit_cnt),
    .o_err_cnt  (o_err_cnt)
  );

  // clock / reset
  initial begin
    tb_clk = 1'b0;
    forever #5 tb_clk = ~tb_clk;
  end

  int            n_vec;
  int            n_miss;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  bit            prbs[N_PRBS];
  int            sym_n;

  // reference model state
  int     m_cnt;
  bit     m_locked;
  int     m_delay;
  int     m_win_n;
  int     m_win_err;
  longint m_bits;
  longint m_errs;
  bit     ref_hist[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt     = 0;
    m_locked  = 1'b0;
    m_delay   = 0;
    m_win_n   = 0;
    m_win_err = 0;
    m_bits    = 0;
    m_errs    = 0;
    ref_hist.delete();
    sym_n     = 0;
  endtask

  task automatic model_strobe(input logic [7:0] d, input bit r);
    bit b;
    bit rb;
    bit e;
    b  = ($signed(d) < 0);
    rb = (m_delay < ref_hist.size()) ? ref_hist[m_delay] : 1'b0;
    e  = b ^ rb;
    if (!m_locked) begin
      m_win_n++;
      m_win_err += int'(e);
      if (m_win_n == SEARCH_WIN) begin
        if (m_win_err == 0) begin
          m_locked = 1'b1;
          m_bits   = 0;
          m_errs   = 0;
        end else begin
          m_delay = (m_delay + 1) % DELAY_LEN;
        end
        m_win_n   = 0;
        m_win_err = 0;
      end
    end else begin
      if (m_bits < CNT_MAX) m_bits++;
      if (e && (m_errs < CNT_MAX)) m_errs++;
`ifdef BER_RELOCK_EN
      m_win_n++;
      m_win_err += int'(e);
      if (m_win_n == SEARCH_WIN) begin
        if (m_win_err > RELOCK_TH) begin
          m_locked = 1'b0;
          m_delay  = (m_delay + 1) % DELAY_LEN;
        end
        m_win_n   = 0;
        m_win_err = 0;
      end
`endif
    end
    ref_hist.push_front(r);
    if (ref_hist.size() > DELAY_LEN) void'(ref_hist.pop_back());
    exp_q.push_back({b, m_locked, DW'(m_delay), NB_CNT'(m_bits), NB_CNT'(m_errs)});
  endtask

  // driver tasks
  function automatic logic [7:0] enc(input bit b);
    if (b) return 8'(0 - $urandom_range(1, 128));
    return 8'($urandom_range(1, 127));
  endfunction

  task automatic drive_clk(input logic [7:0] d, input bit r, input bit en);
    i_is_data = d;
    i_ref_bit = r;
    i_en      = en;
    if (en && (m_cnt == int'(i_phase))) model_strobe(d, r);
    if (en) m_cnt = (m_cnt + 1) % OS;
    @(posedge tb_clk);
    #1;
  endtask

  task automatic send_sym(input int only_ph, input bit inv, input bit gaps);
    bit          r;
    bit          dbit;
    int          k;
    logic [7:0]  d;
    r    = prbs[sym_n];
    dbit = (sym_n >= 5) ? prbs[sym_n-5] : 1'b0;
    if (inv) dbit = ~dbit;
    k = 0;
    while (k < OS) begin
      if (gaps && ($urandom_range(0, 7) == 0)) begin
        drive_clk(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        d = ((only_ph < 0) || (only_ph == k)) ? enc(dbit) : 8'h00;
        drive_clk(d, r, 1'b1);
        k++;
      end
    end
    sym_n++;
  endtask

  task automatic run_syms(input int n, input int only_ph, input int inv_lo, input int inv_hi,
                          input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_sym(only_ph, (sym_n >= inv_lo) && (sym_n < inv_hi), gaps);
    end
  endtask

  task automatic do_reset();
    i_srst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_en      = 1'($urandom_range(0, 1));
      i_is_data = 8'($urandom);
      i_ref_bit = 1'($urandom_range(0, 1));
      @(posedge tb_clk);
      #1;
      chk("rst_sym_valid", o_sym_valid, 0);
      chk("rst_sym_bit", o_sym_bit, 0);
      chk("rst_locked", o_locked, 0);
      chk("rst_delay", o_delay, 0);
      chk("rst_bit_cnt", o_bit_cnt, 0);
      chk("rst_err_cnt", o_err_cnt, 0);
    end
    chk("rst_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    i_srst = 1'b0;
    i_en   = 1'b0;
    model_reset();
  endtask

  // scoreboard monitor
  always @(negedge tb_clk) begin
    if (o_sym_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sym_valid: unexpected pulse, got 1 expected 0");
      end else begin
        mon_e = exp_q.pop_front();
        chk("sym_bit", o_sym_bit, mon_e[EW-1]);
        chk("sym_locked", o_locked, mon_e[EW-2]);
        chk("sym_delay", o_delay, mon_e[EW-3 -: DW]);
        chk("sym_bit_cnt", o_bit_cnt, mon_e[2*NB_CNT-1 -: NB_CNT]);
        chk("sym_err_cnt", o_err_cnt, mon_e[NB_CNT-1:0]);
      end
    end
  end

  initial begin
    logic [8:0] s;
    n_vec     = 0;
    n_miss    = 0;
    i_srst    = 1'b1;
    i_en      = 1'b0;
    i_is_data = '0;
    i_ref_bit = 1'b0;
    i_phase   = 2'd0;
    model_reset();
    s = 9'h1FF;
    for (int i = 0; i < N_PRBS; i++) begin
      prbs[i] = s[8];
      s = {s[7:0], s[8] ^ s[4]};
    end

    do_reset();

    // search and lock at delay 4 after 160 strobes
    i_phase = 2'd0;
    run_syms(159, -1, -1, -1, 1'b1);
    chk("not_locked_159", o_locked, 0);
    run_syms(1, -1, -1, -1, 1'b1);
    chk("locked_160", o_locked, 1);
    chk("lock_delay", o_delay, 4);
    chk("lock_bits_zero", o_bit_cnt, 0);
    run_syms(40, -1, -1, -1, 1'b1);
    chk("bits_40", o_bit_cnt, 40);
    chk("errs_0", o_err_cnt, 0);

    // single inverted symbol
    run_syms(40, -1, 210, 211, 1'b1);
    chk("one_err", o_err_cnt, 1);
    chk("bits_80", o_bit_cnt, 80);
    chk("still_locked", o_locked, 1);

    // freeze with i_en low, then resume at a different phase
    for (int i = 0; i < 100; i++) drive_clk(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    chk("frz_bits", o_bit_cnt, 80);
    chk("frz_errs", o_err_cnt, 1);
    chk("frz_delay", o_delay, 4);
    chk("frz_locked", o_locked, 1);
    i_phase = 2'($urandom_range(1, 3));
    run_syms(20, -1, -1, -1, 1'b1);
    chk("resume_bits", o_bit_cnt, 100);
    chk("resume_errs", o_err_cnt, 1);

    // energy only at phase 2
    do_reset();
    i_phase = 2'd2;
    run_syms(200, 2, -1, -1, 1'b1);
    chk("ph2_locked", o_locked, 1);
    chk("ph2_delay", o_delay, 4);
    chk("ph2_errs", o_err_cnt, 0);
    chk("ph2_bits", o_bit_cnt, 40);

    // wrong phase never locks; delay wraps 510 -> 0
    do_reset();
    i_phase = 2'd1;
    run_syms(510 * SEARCH_WIN, 2, -1, -1, 1'b0);
    chk("wrap_delay_510", o_delay, 510);
    chk("wrap_unlocked_a", o_locked, 0);
    run_syms(SEARCH_WIN, 2, -1, -1, 1'b0);
    chk("wrap_delay_0", o_delay, 0);
    chk("wrap_unlocked_b", o_locked, 0);

    // burst of 8 errors inside one locked window
    do_reset();
    i_phase = 2'd0;
    run_syms(192, -1, -1, -1, 1'b1);
    chk("burst_pre_bits", o_bit_cnt, 32);
    run_syms(32, -1, 192, 200, 1'b1);
    chk("burst_errs", o_err_cnt, 8);
    chk("burst_bits", o_bit_cnt, 64);
`ifdef BER_RELOCK_EN
    chk("burst_unlocked", o_locked, 0);
    chk("burst_delay", o_delay, 5);
`else
    chk("burst_locked", o_locked, 1);
    chk("burst_delay", o_delay, 4);
`endif

    drive_clk(8'h00, 1'b0, 1'b0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
